// File: rtl/grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wb_arbiter
//
// Owns the single write port of the general register file (GRF) and shares it
// between two writers:
//   * the pipeline W-stage, which always wins when it writes, and
//   * an auxiliary long-latency writer (mult/div unit or coprocessor), whose
//     results wait in a small FIFO and drain in cycles the pipeline leaves
//     free.
// Queued entries can be squashed by a younger pipeline write to the same
// register. A hazard query reports whether a register still has a pending aux
// write. If the FIFO head is blocked for too long, a registered stall request
// asks the pipeline to leave a slot free.
//
// Parameters
//   DEPTH        aux FIFO entries (power of two, >= 2)
//   STARVE_LIMIT consecutive blocked cycles of a valid head before stall_req
//
// Ports
//   clk, reset               clock; synchronous active-low reset
//   p_we/p_addr/p_data/p_pc  pipeline write request (never back-pressured)
//   a_valid/a_ready          aux handshake (accepted when both are high)
//   a_addr/a_data/a_pc       aux write payload
//   q_addr1/q_addr2          hazard query addresses
//   q_busy1/q_busy2          a valid queued aux write targets the query address
//   grf_we/grf_a3/grf_wd     registered GRF write port
//   grf_wpc                  registered PC of the instruction being written
//   stall_req                registered: pipeline must not assert p_we
//   proto_err                sticky: p_we seen while stall_req was high
// -----------------------------------------------------------------------------
module grf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p_we,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,

    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy1,
    output logic        q_busy2,

    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_wpc,

    output logic        stall_req,
    output logic        proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_LIMIT) + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_LIMIT - 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_entry_t;

    // FIFO storage. vld[i] is set only for occupied, not-yet-squashed slots,
    // so an occupied slot with vld clear is a squashed entry waiting to be
    // discarded when it reaches the head.
    wb_entry_t         mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [WW-1:0]     wait_cnt;

    // Per-cycle decisions
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_valid;
    logic              accept;
    logic              acc_keep;
    logic              grant_head;
    logic              drop_head;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              squash;
    logic [DEPTH-1:0]  squash_hit;
    logic              head_squashed;
    logic [DEPTH-1:0]  vld_nxt;
    logic [WW-1:0]     wait_nxt;
    logic              stall_nxt;
    wb_entry_t         head_entry;
    wb_entry_t         aux_entry;

    // -------------------------------------------------------------------------
    // Handshake, grant and FIFO bookkeeping
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_COUNT);
        head_valid = !fifo_empty && vld[rd_ptr];
        head_entry = mem[rd_ptr];
        aux_entry  = '{addr: a_addr, data: a_data, pc: a_pc};

        a_ready    = !fifo_full && reset;
        accept     = a_valid && a_ready;
        // Writes to $0 complete the handshake but carry no architectural
        // effect, so they are never queued or written.
        acc_keep   = accept && (a_addr != 5'd0);

        grant_head = !p_we && head_valid;
        // A squashed head is discarded in any cycle; it never takes the port.
        drop_head  = !fifo_empty && !vld[rd_ptr];
        pop        = grant_head || drop_head;
        // Empty FIFO and a free port: hand the aux write straight through.
        bypass     = !p_we && fifo_empty && acc_keep;
        push       = acc_keep && !bypass;

        // The pipeline write is younger than anything already queued, so an
        // older queued write to the same register must never land after it.
        squash     = p_we && (p_addr != 5'd0);
        squash_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash_hit[i] = squash && vld[i] && (mem[i].addr == p_addr);
        end
        head_squashed = squash_hit[rd_ptr];

        // The slot being pushed is never the one being popped: a push needs
        // a free slot and a pop needs an occupied one.
        vld_nxt = vld & ~squash_hit;
        if (pop) begin
            vld_nxt[rd_ptr] = 1'b0;
        end
        if (push) begin
            vld_nxt[wr_ptr] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation tracking
    // -------------------------------------------------------------------------
    // wait_cnt saturates at STARVE_LIMIT-1 so that a pipeline ignoring
    // stall_req keeps the request asserted instead of wrapping the counter.
    always_comb begin
        wait_nxt  = wait_cnt;
        stall_nxt = stall_req;

        if (pop || fifo_empty) begin
            wait_nxt = '0;
        end else if (p_we && head_valid && (wait_cnt != WAIT_MAX)) begin
            wait_nxt = wait_cnt + WW'(1);
        end

        if (p_we && head_valid && (wait_cnt == WAIT_MAX)) begin
            stall_nxt = 1'b1;
        end
        if (pop || head_squashed || fifo_empty) begin
            stall_nxt = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Hazard query: only live (valid) entries count; $0 is never busy.
    // -------------------------------------------------------------------------
    always_comb begin
        q_busy1 = 1'b0;
        q_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (mem[i].addr == q_addr1)) begin
                q_busy1 = 1'b1;
            end
            if (vld[i] && (mem[i].addr == q_addr2)) begin
                q_busy2 = 1'b1;
            end
        end
        if (q_addr1 == 5'd0) begin
            q_busy1 = 1'b0;
        end
        if (q_addr2 == 5'd0) begin
            q_busy2 = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO payload storage
    // -------------------------------------------------------------------------
    // NOTE: the payload array has no reset; an entry is only ever read while
    // its vld bit is set, and vld is cleared on reset, so stale contents are
    // unobservable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= aux_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Control state and registered GRF write port
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            grf_we    <= 1'b0;
            grf_a3    <= '0;
            grf_wd    <= '0;
            grf_wpc   <= '0;
            stall_req <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            vld      <= vld_nxt;
            // Pointers wrap naturally because DEPTH is a power of two.
            rd_ptr   <= rd_ptr + PW'(pop);
            wr_ptr   <= wr_ptr + PW'(push);
            count    <= count + CW'(push) - CW'(pop);
            wait_cnt <= wait_nxt;
            stall_req <= stall_nxt;

            if (p_we && stall_req) begin
                proto_err <= 1'b1;
            end

            // Priority: pipeline, then a live FIFO head, then bypass. When
            // nobody writes, the data/address registers keep their values.
            if (p_we) begin
                grf_we  <= 1'b1;
                grf_a3  <= p_addr;
                grf_wd  <= p_data;
                grf_wpc <= p_pc;
            end else if (grant_head) begin
                grf_we  <= 1'b1;
                grf_a3  <= head_entry.addr;
                grf_wd  <= head_entry.data;
                grf_wpc <= head_entry.pc;
            end else if (bypass) begin
                grf_we  <= 1'b1;
                grf_a3  <= aux_entry.addr;
                grf_wd  <= aux_entry.data;
                grf_wpc <= aux_entry.pc;
            end else begin
                grf_we  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Owns the single write port of the general register file. Shares it between the pipeline W-stage (fixed high priority) and an auxiliary long-latency writer (mult/div unit or coprocessor).
- Aux writes queue in a small FIFO and drain in cycles where the pipeline does not write.
- Exposes a pending-write query for the hazard unit and a starvation stall request to the pipeline.

Parameters:
- DEPTH, 2: aux FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4: consecutive cycles a valid head may wait before stall_req is raised.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-low: reset==0 on a rising edge resets the block.
- p_we  in  1  pipeline write request; never back-pressured.
- p_addr  in  5  pipeline destination register.
- p_data  in  32  pipeline write data.
- p_pc  in  32  pipeline instruction PC.
- a_valid  in  1  aux write valid.
- a_ready  out  1  aux may be accepted this cycle.
- a_addr  in  5  aux destination register.
- a_data  in  32  aux write data.
- a_pc  in  32  aux instruction PC.
- q_addr1  in  5  hazard query address 1.
- q_addr2  in  5  hazard query address 2.
- q_busy1  out  1  valid queued aux entry targets q_addr1 (nonzero).
- q_busy2  out  1  same for q_addr2.
- grf_we  out  1  GRF write enable (registered).
- grf_a3  out  5  GRF write address (registered).
- grf_wd  out  32  GRF write data (registered).
- grf_wpc  out  32  PC of the write (registered).
- stall_req  out  1  pipeline must not assert p_we while high (registered).
- proto_err  out  1  sticky: p_we seen while stall_req==1.

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO emptied, all entry valid bits cleared, wait counter cleared.
  - grf_we, grf_a3, grf_wd, grf_wpc, stall_req and proto_err all 0.
  - a_ready forced 0 while reset==0.
  - Reset mid-drain discards all queued entries; no write is issued.
- Accept:
  - a_ready = (count<DEPTH) && reset.
  - Handshake is a_valid && a_ready at a posedge.
  - a_valid may be held across cycles; a_addr, a_data and a_pc must stay stable while a_valid && !a_ready.
  - An accepted aux write with a_addr==0 completes the handshake but is dropped (never queued, never written).
- Port grant per cycle, result registered to grf_* at that posedge (1-cycle latency):
  1. p_we=1: the pipeline write wins; grf_we<=1, grf_a3<=p_addr (including 0; the GRF handles $0), grf_wd<=p_data, grf_wpc<=p_pc.
  2. Else, if the FIFO head is valid: pop the head, grf_*<=head, grf_we<=1.
  3. Else, if the FIFO is empty and an aux is accepted this cycle (nonzero addr): bypass, grf_*<=aux inputs. Counts as accept+pop; the FIFO stays empty.
  4. Else grf_we<=0. The other grf_* outputs hold their previous values.
- Invalid head entries are popped silently in any cycle, including p_we cycles, without a write and without consuming the grant.
- Squash: a p_we with nonzero p_addr invalidates every queued entry whose addr equals p_addr (the pipeline write is younger).
  - An aux accepted in the same cycle with the same address is not squashed; it is younger.
- Same-cycle accept and pop is allowed; count changes by +1, 0 or -1 accordingly.
- Pointers wrap modulo DEPTH.
- Query: q_busyN is combinational over valid entries only and is 0 for address 0.
- Starvation:
  - wait_cnt increments each cycle the head is valid and p_we=1.
  - wait_cnt clears on pop, when the FIFO is empty, or on reset.
  - stall_req<=1 when wait_cnt reaches STARVE_LIMIT-1 while p_we=1 and the head is valid.
  - stall_req<=0 the cycle after the head pops or is squashed.
  - If p_we=1 while stall_req=1, the pipeline still wins and proto_err<=1 (sticky until reset).

Test Plan:
- Reset: hold reset=0 two cycles with a_valid=1 and p_we=1 -> a_ready=0, grf_we=0, all outputs 0; release -> a_ready=1 next cycle.
- Bypass: idle pipeline, aux {addr 5, data 0x1234, pc 0x3008} -> a_ready=1, next cycle grf_we=1, a3=5, wd=0x1234, wpc=0x3008; FIFO stays empty.
- Queue and drain: p_we=1 for 3 cycles (addrs 1,2,3) while aux sends addr 8 then addr 9 -> grf writes 1,2,3,8,9 in order; a_ready=0 after the second accept; q_busy1=1 for q_addr1=8 until 8 drains.
- Squash: queue aux addr 7, then p_we addr 7 data 0xAA -> grf writes 7<=0xAA only; q_busy for 7 drops the next cycle; aux 7 is never written.
- Starvation: queue one aux entry, keep p_we=1 -> stall_req=1 after 4 cycles; drop p_we -> entry written next cycle, stall_req=0 after; repeat with p_we held high while stall_req=1 -> proto_err=1 until reset.
- $0 handling: aux addr 0 accepted -> no write, count unchanged; p_we addr 0 -> grf_we=1, a3=0 passed through.
